// File: rtl/vector_redsum_unit.sv
// vector_redsum_unit: multi-cycle integer reduction-sum execute unit.
// Computes vd = vs1[0] + sum(vs2[*]) one VLEN-bit chunk per cycle. A single
// chunk-wide adder tree is reused across the LMUL beats. The result is
// presented on vd_bus together with a one-cycle done/wb_enable pulse.
//
// Handshake: start is a request that is sampled only in IDLE and is never
// queued. busy is high from the cycle after acceptance until the DONE cycle
// ends. done and wb_enable are the same single-cycle pulse, and vd_bus is
// valid in that cycle. vd_bus then holds its value until the next completion
// or reset. There is no backpressure; the writeback stage must take the
// result in the done cycle.
module vector_redsum_unit #(
  parameter int VLEN       = 128,
  parameter int MAX_CHUNKS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         vsi_lmul,
  input  logic                         vsi_sew,
  input  logic [VLEN-1:0]              vs1_data,
  input  logic [VLEN*MAX_CHUNKS-1:0]   vs2_data,
  output logic                         busy,
  output logic                         done,
  output logic                         wb_enable,
  output logic [VLEN*MAX_CHUNKS-1:0]   vd_bus,
  output logic [1:0]                   dbg_state_o
);

  localparam int BUS_W   = VLEN * MAX_CHUNKS;
  localparam int BEAT_W  = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int N_BYTES = VLEN / 8;
  localparam int N_WORDS = VLEN / 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q,  beat_d;
  logic                lmul_q,  lmul_d;
  logic                sew_q,   sew_d;
  logic [BUS_W-1:0]    vs2_q,   vs2_d;
  logic [31:0]         acc_q,   acc_d;
  logic [BUS_W-1:0]    vd_q,    vd_d;

  logic [VLEN-1:0]     chunk;
  logic [7:0]          byte_sum;
  logic [31:0]         word_sum;
  logic [31:0]         acc_next;
  logic [31:0]         seed;
  logic [BEAT_W-1:0]   last_beat_idx;
  logic                last_beat;

  // Only element 0 of vs1 feeds the seed; the remaining bits are ignored.
  logic unused_vs1_hi;
  assign unused_vs1_hi = ^vs1_data[VLEN-1:32];

  // Modulo-2^8 sum of every byte in one chunk.
  function automatic logic [7:0] sum_bytes(input logic [VLEN-1:0] c);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      s = s + c[i*8 +: 8];
    end
    return s;
  endfunction

  // Modulo-2^32 sum of every 32-bit word in one chunk.
  function automatic logic [31:0] sum_words(input logic [VLEN-1:0] c);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < N_WORDS; i++) begin
      s = s + c[i*32 +: 32];
    end
    return s;
  endfunction

  // Select the latched chunk addressed by the current beat.
  always_comb begin
    chunk = '0;
    for (int k = 0; k < MAX_CHUNKS; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        chunk = vs2_q[k*VLEN +: VLEN];
      end
    end
  end

  // Shared adder tree plus accumulate; wraps at the latched element width.
  always_comb begin
    byte_sum = sum_bytes(chunk);
    word_sum = sum_words(chunk);
    if (sew_q) begin
      acc_next = acc_q + word_sum;
    end else begin
      acc_next = {24'h0, acc_q[7:0] + byte_sum};
    end
  end

  // Seed selection and last-beat detection.
  always_comb begin
    seed          = vsi_sew ? vs1_data[31:0] : {24'h0, vs1_data[7:0]};
    last_beat_idx = lmul_q ? BEAT_W'(MAX_CHUNKS - 1) : '0;
    last_beat     = (beat_q == last_beat_idx);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand latch in IDLE, accumulate in ACCUM.
  always_comb begin
    beat_d = beat_q;
    lmul_d = lmul_q;
    sew_d  = sew_q;
    vs2_d  = vs2_q;
    acc_d  = acc_q;
    vd_d   = vd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vs2_d  = vs2_data;
          lmul_d = vsi_lmul;
          sew_d  = vsi_sew;
          acc_d  = seed;
          beat_d = '0;
        end
      end
      S_ACCUM: begin
        acc_d  = acc_next;
        beat_d = beat_q + BEAT_W'(1);
        // The result register is loaded on the same edge that enters DONE.
        if (last_beat) begin
          vd_d = BUS_W'(acc_next);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an abort leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      lmul_q <= 1'b0;
      sew_q  <= 1'b0;
      vs2_q  <= '0;
      acc_q  <= '0;
      vd_q   <= '0;
    end else begin
      beat_q <= beat_d;
      lmul_q <= lmul_d;
      sew_q  <= sew_d;
      vs2_q  <= vs2_d;
      acc_q  <= acc_d;
      vd_q   <= vd_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    wb_enable   = (state_q == S_DONE);
    vd_bus      = vd_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_vector_redsum_unit.sv
// Directed testbench for vector_redsum_unit with hand-computed expected sums.
module tb_vector_redsum_unit;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         vsi_lmul;
  logic         vsi_sew;
  logic [127:0] vs1_data;
  logic [511:0] vs2_data;
  logic         busy;
  logic         done;
  logic         wb_enable;
  logic [511:0] vd_bus;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  vector_redsum_unit #(.VLEN(128), .MAX_CHUNKS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vsi_lmul    (vsi_lmul),
    .vsi_sew     (vsi_sew),
    .vs1_data    (vs1_data),
    .vs2_data    (vs2_data),
    .busy        (busy),
    .done        (done),
    .wb_enable   (wb_enable),
    .vd_bus      (vd_bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive operands at posedge+1, hold start through one sampling edge (T).
  // Returns at T+1.
  task automatic launch(input logic lmul, input logic sew,
                        input logic [127:0] v1, input logic [511:0] v2);
    @(posedge clk); #1;
    vsi_lmul = lmul;
    vsi_sew  = sew;
    vs1_data = v1;
    vs2_data = v2;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Wait for done; cyc counts edges after the sampling edge, -1 on timeout.
  task automatic wait_done(input int budget, output int cyc,
                           output logic [511:0] vd_s, output logic we_s);
    cyc  = -1;
    vd_s = '0;
    we_s = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cyc  = n;
        vd_s = vd_bus;
        we_s = wb_enable;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    vsi_lmul = 1'b0;
    vsi_sew  = 1'b0;
    vs1_data = '0;
    vs2_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wb_enable !== 1'b0) begin n_bad++; $display("FAIL reset_wb: got %b want 0", wb_enable); end
    n_cmp++; if (vd_bus !== 512'h0) begin n_bad++; $display("FAIL reset_vd: got %h want 0", vd_bus); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_basic();
    logic [511:0] v2;
    logic [511:0] vd_s;
    logic         we_s;
    int           cyc;
    // Chunk 0 bytes = 0x01; upper chunks are junk that lmul=0 must ignore.
    v2 = {{48{8'hEE}}, {16{8'h01}}};
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL byte_idle_busy: got %b want 0", busy); end
    launch(1'b0, 1'b0, 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_0000_7705, v2);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL byte_busy_rise: got %b want 1", busy); end
    wait_done(10, cyc, vd_s, we_s);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL byte_latency: got %0d want 1 edge after sampling", cyc); end
    n_cmp++; if (vd_s !== 512'h15) begin n_bad++; $display("FAIL byte_result: got %h want 15", vd_s); end
    n_cmp++; if (we_s !== 1'b1) begin n_bad++; $display("FAIL byte_wb: got %b want 1", we_s); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL byte_done_pulse: got %b want 0", done); end
    n_cmp++; if (vd_bus !== 512'h15) begin n_bad++; $display("FAIL byte_vd_hold: got %h want 15", vd_bus); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL byte_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_byte_wrap();
    logic [511:0] vd_s;
    logic         we_s;
    int           cyc;
    // 64 * 0xFF = 0x3FC0 -> 0xC0 modulo 2^8.
    launch(1'b1, 1'b0, 128'h0, {64{8'hFF}});
    wait_done(20, cyc, vd_s, we_s);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL wrap_latency: got %0d want 4", cyc); end
    n_cmp++; if (vd_s !== 512'hC0) begin n_bad++; $display("FAIL wrap_result: got %h want c0", vd_s); end
    n_cmp++; if (we_s !== 1'b1) begin n_bad++; $display("FAIL wrap_wb: got %b want 1", we_s); end
  endtask

  task automatic test_word();
    logic [511:0] v2;
    logic [511:0] vd_s;
    logic         we_s;
    int           cyc;
    for (int k = 0; k < 16; k++) v2[k*32 +: 32] = 32'(k + 1);
    // 1+..+16 = 136, plus 100 = 236 = 0xEC.
    launch(1'b1, 1'b1, 128'h0000_00AA_0000_0000_0000_0000_0000_0064, v2);
    wait_done(20, cyc, vd_s, we_s);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL word_latency: got %0d want 4", cyc); end
    n_cmp++; if (vd_s !== 512'hEC) begin n_bad++; $display("FAIL word_result: got %h want ec", vd_s); end
    // 0xFFFFFFFF + 2 wraps to 1.
    v2 = '0;
    v2[31:0] = 32'hFFFF_FFFF;
    launch(1'b1, 1'b1, 128'h2, v2);
    wait_done(20, cyc, vd_s, we_s);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL word_wrap_latency: got %0d want 4", cyc); end
    n_cmp++; if (vd_s !== 512'h1) begin n_bad++; $display("FAIL word_wrap_result: got %h want 1", vd_s); end
  endtask

  task automatic test_busy_start();
    logic [511:0] va;
    logic [511:0] vd_at4;
    logic [511:0] vd_at7;
    logic         busy_at5;
    int           n_done;
    int           done_mask;
    for (int k = 0; k < 16; k++) va[k*32 +: 32] = 32'(k + 1);
    // A: sew=1 lmul=1, 136 + 0x10 = 0x98.
    launch(1'b1, 1'b1, 128'h10, va);
    n_done    = 0;
    done_mask = 0;
    vd_at4    = '0;
    vd_at7    = '0;
    busy_at5  = 1'bx;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      start = (n == 2) || (n == 4) || (n == 5);
      if (n == 2 || n == 4) begin
        // B: would give 0x73 if wrongly accepted or if latching failed.
        vsi_lmul = 1'b1;
        vsi_sew  = 1'b0;
        vs1_data = 128'h33;
        vs2_data = {64{8'h11}};
      end else if (n == 5) begin
        // C: sew=0 lmul=0, 16*3 + 7 = 0x37.
        vsi_lmul = 1'b0;
        vsi_sew  = 1'b0;
        vs1_data = 128'h7;
        vs2_data = {64{8'h03}};
      end
      @(negedge clk);
      if (done) begin
        n_done++;
        done_mask = done_mask | (1 << n);
      end
      if (n == 4) vd_at4 = vd_bus;
      if (n == 5) busy_at5 = busy;
      if (n == 7) vd_at7 = vd_bus;
    end
    start = 1'b0;
    n_cmp++; if (n_done !== 2) begin n_bad++; $display("FAIL busy_done_count: got %0d want 2", n_done); end
    n_cmp++; if (done_mask !== ((1 << 4) | (1 << 7))) begin n_bad++; $display("FAIL busy_done_cycles: got mask %h want %h", done_mask, (1 << 4) | (1 << 7)); end
    n_cmp++; if (vd_at4 !== 512'h98) begin n_bad++; $display("FAIL busy_first_result: got %h want 98", vd_at4); end
    n_cmp++; if (busy_at5 !== 1'b0) begin n_bad++; $display("FAIL busy_idle_gap: got %b want 0", busy_at5); end
    n_cmp++; if (vd_at7 !== 512'h37) begin n_bad++; $display("FAIL busy_relaunch_result: got %h want 37", vd_at7); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] va;
    logic [511:0] vd_s;
    logic         we_s;
    int           cyc;
    int           n_done;
    for (int k = 0; k < 16; k++) va[k*32 +: 32] = 32'(k + 1);
    launch(1'b1, 1'b1, 128'h10, va);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Now in ACCUM beat 2.
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (wb_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_wb: got %b want 0", wb_enable); end
    n_cmp++; if (vd_bus !== 512'h0) begin n_bad++; $display("FAIL midrst_vd: got %h want 0", vd_bus); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || wb_enable) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
    // Fresh start: 4 * 0x10000000 + 5, upper vs1 bits must not leak in.
    va = {{12{32'hCAFE_0000}}, {4{32'h1000_0000}}};
    launch(1'b0, 1'b1, 128'h0000_0000_0000_0000_0000_00AB_0000_0005, va);
    wait_done(10, cyc, vd_s, we_s);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL midrst_fresh_latency: got %0d want 1", cyc); end
    n_cmp++; if (vd_s !== 512'h4000_0005) begin n_bad++; $display("FAIL midrst_fresh_result: got %h want 40000005", vd_s); end
  endtask

  initial begin
    test_reset();
    test_byte_basic();
    test_byte_wrap();
    test_word();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
